// File: rtl/dma_pkg.sv
// Shared definitions for the DMA copy engine: FSM state encoding and the
// bus-ownership select values that the data memory also decodes.
package dma_pkg;

  localparam logic [2:0] ENC_IDLE    = 3'd0;
  localparam logic [2:0] ENC_ACQUIRE = 3'd1;
  localparam logic [2:0] ENC_READ    = 3'd2;
  localparam logic [2:0] ENC_WRITE   = 3'd3;
  localparam logic [2:0] ENC_DONE    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = ENC_IDLE,
    ST_ACQUIRE = ENC_ACQUIRE,
    ST_READ    = ENC_READ,
    ST_WRITE   = ENC_WRITE,
    ST_DONE    = ENC_DONE
  } dma_state_t;

  localparam logic CPU_CTRL = 1'b0;
  localparam logic DMA_CTRL = 1'b1;

endpackage

// File: rtl/dma_copy_engine.sv
// Word-granular memory-to-memory copy engine owning the DMA port of the L1
// data memory; copies ascending at two cycles per word while stalling the CPU.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int NUM_WORDS       = 128
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst,
  input  logic                       dma_start,
  input  logic [DATA_ADDR_WIDTH-1:0] dma_src,
  input  logic [DATA_ADDR_WIDTH-1:0] dma_dst,
  input  logic [DATA_ADDR_WIDTH-1:0] dma_len,
  input  logic                       dma_abort,
  input  logic                       cpu_mem_idle,
  input  logic [DATA_WIDTH-1:0]      data_mem_rdata,
  output logic [DATA_ADDR_WIDTH-1:0] dma_data_mem_raddr,
  output logic [DATA_ADDR_WIDTH-1:0] dma_data_mem_waddr,
  output logic [DATA_WIDTH-1:0]      dma_data_mem_wdata,
  output logic                       dma_data_mem_write,
  output logic                       data_mem_read_ctrl_by,
  output logic                       data_mem_write_ctrl_by,
  output logic                       cpu_mem_stall,
  output logic                       dma_busy,
  output logic                       dma_done,
  output logic                       dma_error,
  output logic                       dma_aborted
);

  typedef logic [DATA_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_ADDR_WIDTH:0]   sum_t;

  localparam sum_t  MEM_LIMIT = sum_t'(NUM_WORDS);
  localparam addr_t ONE       = addr_t'(1);

  dma_state_t            state_reg;
  addr_t                 src_reg;
  addr_t                 dst_reg;
  addr_t                 len_reg;
  addr_t                 idx_reg;
  addr_t                 idx_next;
  logic [DATA_WIDTH-1:0] buf_reg;
  logic                  error_reg;
  logic                  aborted_reg;
  sum_t                  src_end;
  sum_t                  dst_end;
  logic                  bounds_bad;

  // One extra bit so a wrapping end address still counts as out of range.
  assign src_end    = {1'b0, dma_src} + {1'b0, dma_len};
  assign dst_end    = {1'b0, dma_dst} + {1'b0, dma_len};
  assign bounds_bad = (src_end > MEM_LIMIT) || (dst_end > MEM_LIMIT);
  assign idx_next   = idx_reg + ONE;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_reg   <= ST_IDLE;
      src_reg     <= '0;
      dst_reg     <= '0;
      len_reg     <= '0;
      idx_reg     <= '0;
      buf_reg     <= '0;
      error_reg   <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (dma_start) begin
            src_reg     <= dma_src;
            dst_reg     <= dma_dst;
            len_reg     <= dma_len;
            idx_reg     <= '0;
            error_reg   <= 1'b0;
            aborted_reg <= 1'b0;
            if (dma_len == '0) begin
              state_reg <= ST_DONE;
            end else if (bounds_bad) begin
              error_reg <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              state_reg <= ST_ACQUIRE;
            end
          end
        end
        ST_ACQUIRE: begin
          if (dma_abort) begin
            aborted_reg <= 1'b1;
            state_reg   <= ST_DONE;
          end else if (cpu_mem_idle) begin
            state_reg <= ST_READ;
          end
        end
        ST_READ: begin
          if (dma_abort) begin
            aborted_reg <= 1'b1;
            state_reg   <= ST_DONE;
          end else begin
            buf_reg   <= data_mem_rdata;
            state_reg <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // The write on the bus this cycle always lands, abort or not.
          idx_reg <= idx_next;
          if (dma_abort) begin
            aborted_reg <= 1'b1;
            state_reg   <= ST_DONE;
          end else if (idx_next == len_reg) begin
            state_reg <= ST_DONE;
          end else begin
            state_reg <= ST_READ;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign dma_busy               = (state_reg != ST_IDLE);
  assign cpu_mem_stall          = (state_reg == ST_ACQUIRE) || (state_reg == ST_READ) ||
                                  (state_reg == ST_WRITE);
  assign data_mem_read_ctrl_by  = (state_reg == ST_READ)  ? DMA_CTRL : CPU_CTRL;
  assign data_mem_write_ctrl_by = (state_reg == ST_WRITE) ? DMA_CTRL : CPU_CTRL;
  assign dma_data_mem_raddr     = (state_reg == ST_READ)  ? src_reg + idx_reg : '0;
  assign dma_data_mem_waddr     = (state_reg == ST_WRITE) ? dst_reg + idx_reg : '0;
  assign dma_data_mem_wdata     = (state_reg == ST_WRITE) ? buf_reg : '0;
  assign dma_data_mem_write     = (state_reg == ST_WRITE);
  assign dma_done               = (state_reg == ST_DONE);
  assign dma_error              = dma_done && error_reg;
  assign dma_aborted            = dma_done && aborted_reg;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: directed table of transfers, randomized transfers
// against a word-level reference model, and a reset-mid-copy sequence.
module tb_dma_copy_engine;

  logic        cpu_clk;
  logic        cpu_rst;
  logic        dma_start;
  logic [31:0] dma_src;
  logic [31:0] dma_dst;
  logic [31:0] dma_len;
  logic        dma_abort;
  logic        cpu_mem_idle;
  logic [31:0] data_mem_rdata;
  logic [31:0] dma_data_mem_raddr;
  logic [31:0] dma_data_mem_waddr;
  logic [31:0] dma_data_mem_wdata;
  logic        dma_data_mem_write;
  logic        data_mem_read_ctrl_by;
  logic        data_mem_write_ctrl_by;
  logic        cpu_mem_stall;
  logic        dma_busy;
  logic        dma_done;
  logic        dma_error;
  logic        dma_aborted;

  dma_copy_engine #(
    .DATA_WIDTH(32), .DATA_ADDR_WIDTH(32), .NUM_WORDS(128)
  ) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .dma_start(dma_start),
    .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
    .dma_abort(dma_abort), .cpu_mem_idle(cpu_mem_idle),
    .data_mem_rdata(data_mem_rdata),
    .dma_data_mem_raddr(dma_data_mem_raddr), .dma_data_mem_waddr(dma_data_mem_waddr),
    .dma_data_mem_wdata(dma_data_mem_wdata), .dma_data_mem_write(dma_data_mem_write),
    .data_mem_read_ctrl_by(data_mem_read_ctrl_by),
    .data_mem_write_ctrl_by(data_mem_write_ctrl_by),
    .cpu_mem_stall(cpu_mem_stall), .dma_busy(dma_busy), .dma_done(dma_done),
    .dma_error(dma_error), .dma_aborted(dma_aborted)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Data memory: combinational read, write on the clock edge.
  logic [31:0] mem     [128];
  logic [31:0] exp_mem [128];
  assign data_mem_rdata = mem[dma_data_mem_raddr[6:0]];
  always @(posedge cpu_clk)
    if (dma_data_mem_write) mem[dma_data_mem_waddr[6:0]] = dma_data_mem_wdata;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    int          idle_low;    // cpu_mem_idle low through this cycle
    int          abort_cyc;   // cycle with dma_abort high, -1 none
    int          restart_cyc; // cycle with a spurious dma_start, -1 none
    int          e_done;
    bit          e_err;
    bit          e_abt;
    int          e_wr;
    string       name;
  } xfer_t;

  int total;
  int bad;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Word-level model: timeline arithmetic plus an ascending element-by-element copy.
  task automatic model(input xfer_t x, output int e_done, output bit e_err, output bit e_abt,
                       output int e_wr, output int e_stall, output int e_ctrl);
    longint s_end = longint'(x.src) + longint'(x.len);
    longint d_end = longint'(x.dst) + longint'(x.len);
    int r0 = x.idle_low + 2;
    int a  = x.abort_cyc;
    int n;
    int normal_done;
    int acq;
    e_err = 0; e_abt = 0; e_wr = 0; e_stall = 0; e_ctrl = 0; e_done = 1;
    if (x.len == 0) return;
    if (s_end > 128 || d_end > 128) begin
      e_err = 1;
      return;
    end
    n = int'(x.len);
    normal_done = r0 + 2 * n;
    if (a >= 1 && a <= r0 - 1) begin
      e_done = a + 1; e_abt = 1; acq = a;
    end else if (a >= r0 && a < normal_done) begin
      e_wr = (a - r0) / 2 + (((a - r0) % 2 == 1) ? 1 : 0);
      e_done = a + 1; e_abt = 1; acq = r0 - 1;
    end else begin
      e_done = normal_done; e_wr = n; acq = r0 - 1;
    end
    e_stall = e_done - 1;
    e_ctrl  = e_done - 1 - acq;
    for (int k = 0; k < e_wr; k++)
      exp_mem[int'(x.dst) + k] = exp_mem[int'(x.src) + k];
  endtask

  task automatic run_xfer(input xfer_t x, input bit from_table);
    int md, mw, ms, mc, done_c, writes, stall_c, ctrl_c, first_rd, mism;
    bit me, ma, err, abt;
    for (int i = 0; i < 128; i++) exp_mem[i] = mem[i];
    model(x, md, me, ma, mw, ms, mc);
    if (from_table) begin
      md = x.e_done; me = x.e_err; ma = x.e_abt; mw = x.e_wr;
    end
    done_c = -1; writes = 0; stall_c = 0; ctrl_c = 0; first_rd = -1; err = 0; abt = 0;
    @(negedge cpu_clk);
    dma_src = x.src; dma_dst = x.dst; dma_len = x.len;
    dma_start = 1'b1;
    cpu_mem_idle = (x.idle_low == 0);
    @(posedge cpu_clk); #1;
    for (int c = 1; c <= 300; c++) begin
      cpu_mem_idle = (c > x.idle_low);
      dma_abort    = (c == x.abort_cyc);
      dma_start    = (c == x.restart_cyc);
      if (c == x.restart_cyc) dma_src = x.src ^ 32'h5;
      @(negedge cpu_clk);
      if (dma_data_mem_write) writes++;
      if (cpu_mem_stall) stall_c++;
      if (data_mem_read_ctrl_by || data_mem_write_ctrl_by) ctrl_c++;
      if (data_mem_read_ctrl_by && first_rd < 0) first_rd = c;
      if (dma_done) begin
        done_c = c; err = dma_error; abt = dma_aborted;
      end
      @(posedge cpu_clk); #1;
      if (done_c >= 0) break;
    end
    dma_start = 1'b0; dma_abort = 1'b0; cpu_mem_idle = 1'b1;
    mism = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== exp_mem[i]) mism++;
    $display("xfer %s src=%0d dst=%0d len=%0d done@%0d err=%0b abt=%0b words=%0d stall=%0d",
             x.name, x.src, x.dst, x.len, done_c, err, abt, writes, stall_c);
    check({x.name, ".done_cycle"}, 64'(done_c), 64'(md));
    check({x.name, ".error"}, 64'(err), 64'(me));
    check({x.name, ".aborted"}, 64'(abt), 64'(ma));
    check({x.name, ".words"}, 64'(writes), 64'(mw));
    check({x.name, ".stall_cycles"}, 64'(stall_c), 64'(ms));
    check({x.name, ".ctrl_cycles"}, 64'(ctrl_c), 64'(mc));
    check({x.name, ".first_read"}, 64'(first_rd), 64'((mc > 0) ? x.idle_low + 2 : -1));
    check({x.name, ".mem_words_wrong"}, 64'(mism), 64'(0));
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
  endtask

  xfer_t tbl [12];
  xfer_t rx;
  logic [31:0] plan_vals [4];

  initial begin
    total = 0; bad = 0;
    cpu_rst = 1'b1; dma_start = 1'b0; dma_src = '0; dma_dst = '0; dma_len = '0;
    dma_abort = 1'b0; cpu_mem_idle = 1'b1;
    plan_vals[0] = 32'd11; plan_vals[1] = 32'd22; plan_vals[2] = 32'd33; plan_vals[3] = 32'd44;
    fill_mem();

    tbl[0]  = '{32'd4,   32'd20, 32'd4,  0, -1, -1, 10, 1'b0, 1'b0, 4, "basic"};
    tbl[1]  = '{32'd0,   32'd0,  32'd0,  0, -1, -1, 1,  1'b0, 1'b0, 0, "len0"};
    tbl[2]  = '{32'd120, 32'd0,  32'd10, 0, -1, -1, 1,  1'b1, 1'b0, 0, "src_oob"};
    tbl[3]  = '{32'd8,   32'd40, 32'd3,  5, -1, -1, 13, 1'b0, 1'b0, 3, "idle_wait"};
    tbl[4]  = '{32'd30,  32'd60, 32'd4,  0, 5,  -1, 6,  1'b0, 1'b1, 2, "abort_wr2"};
    tbl[5]  = '{32'd10,  32'd50, 32'd4,  0, -1, 4,  10, 1'b0, 1'b0, 4, "restart"};
    tbl[6]  = '{32'd0,   32'd1,  32'd3,  0, -1, -1, 8,  1'b0, 1'b0, 3, "overlap"};
    tbl[7]  = '{32'd70,  32'd90, 32'd4,  0, 4,  -1, 5,  1'b0, 1'b1, 1, "abort_rd2"};
    tbl[8]  = '{32'd5,   32'd6,  32'd2,  3, 2,  -1, 3,  1'b0, 1'b1, 0, "abort_acq"};
    tbl[9]  = '{32'd0,   32'hFFFF_FFFF, 32'd2, 0, -1, -1, 1, 1'b1, 1'b0, 0, "dst_wrap"};
    tbl[10] = '{32'd124, 32'd0,  32'd4,  0, -1, -1, 10, 1'b0, 1'b0, 4, "edge_ok"};
    tbl[11] = '{32'd125, 32'd0,  32'd4,  0, -1, -1, 1,  1'b1, 1'b0, 0, "edge_oob"};

    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    check("reset.busy", 64'(dma_busy), 64'(0));
    check("reset.stall", 64'(cpu_mem_stall), 64'(0));
    check("reset.ctrl", 64'({data_mem_read_ctrl_by, data_mem_write_ctrl_by}), 64'(0));
    check("reset.write_done", 64'({dma_data_mem_write, dma_done, dma_error, dma_aborted}), 64'(0));
    check("reset.buses", {dma_data_mem_raddr, dma_data_mem_waddr} | 64'(dma_data_mem_wdata), 64'(0));
    cpu_rst = 1'b0;
    @(posedge cpu_clk); #1;

    for (int i = 0; i < 12; i++) begin
      fill_mem();
      if (i == 0) for (int k = 0; k < 4; k++) mem[4 + k] = plan_vals[k];
      run_xfer(tbl[i], 1'b1);
      if (i == 0)
        for (int k = 0; k < 4; k++)
          check($sformatf("basic.mem%0d", 20 + k), 64'(mem[20 + k]), 64'(plan_vals[k]));
    end

    for (int i = 0; i < 40; i++) begin
      fill_mem();
      rx.src = $urandom_range(0, 127);
      rx.dst = $urandom_range(0, 127);
      rx.len = $urandom_range(0, 12);
      rx.idle_low = int'($urandom_range(0, 3));
      rx.abort_cyc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 28)) : -1;
      rx.restart_cyc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 6)) : -1;
      rx.e_done = 0; rx.e_err = 0; rx.e_abt = 0; rx.e_wr = 0;
      rx.name = $sformatf("rand%0d", i);
      run_xfer(rx, 1'b0);
    end

    // Reset in the middle of a copy.
    @(negedge cpu_clk);
    dma_src = 32'd0; dma_dst = 32'd64; dma_len = 32'd8; dma_start = 1'b1;
    @(posedge cpu_clk); #1;
    dma_start = 1'b0;
    repeat (4) @(posedge cpu_clk);
    @(negedge cpu_clk);
    check("midcopy.busy", 64'(dma_busy), 64'(1));
    cpu_rst = 1'b1;
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    $display("reset mid-copy busy=%0b stall=%0b write=%0b", dma_busy, cpu_mem_stall, dma_data_mem_write);
    check("rst_mid.busy_stall", 64'({dma_busy, cpu_mem_stall}), 64'(0));
    check("rst_mid.ctrl", 64'({data_mem_read_ctrl_by, data_mem_write_ctrl_by}), 64'(0));
    check("rst_mid.write_done", 64'({dma_data_mem_write, dma_done, dma_error, dma_aborted}), 64'(0));
    check("rst_mid.buses", {dma_data_mem_raddr, dma_data_mem_waddr} | 64'(dma_data_mem_wdata), 64'(0));
    cpu_rst = 1'b0;
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    check("post_rst.busy", 64'(dma_busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- Word-granular memory-to-memory copy engine that owns the DMA side of the L1 data memory.
- Drives the data memory's DMA read/write address, write data, write enable and both ctrl_by selects.
- Stalls the CPU memory stage while it holds the memory.
- Started by a one-cycle start pulse carrying source, destination and length. Reports completion, error and abort status.

Parameters:
- DATA_WIDTH, 32, data word width.
- DATA_ADDR_WIDTH, 32, width of the word-address buses and the length bus.
- NUM_WORDS, 128, data memory depth in words; used for the bounds check.

Ports:
- cpu_clk  input  1  single clock.
- cpu_rst  input  1  reset; one clock, reset is synchronous and active-high.
- dma_start  input  1  one-cycle request; sampled only in IDLE.
- dma_src  input  DATA_ADDR_WIDTH  source word address, latched on start.
- dma_dst  input  DATA_ADDR_WIDTH  destination word address, latched on start.
- dma_len  input  DATA_ADDR_WIDTH  word count, latched on start.
- dma_abort  input  1  stop the transfer early.
- cpu_mem_idle  input  1  CPU has no load/store in flight; the bus may be taken.
- data_mem_rdata  input  DATA_WIDTH  combinational read data from data memory.
- dma_data_mem_raddr  output  DATA_ADDR_WIDTH  word read address.
- dma_data_mem_waddr  output  DATA_ADDR_WIDTH  word write address.
- dma_data_mem_wdata  output  DATA_WIDTH  write data.
- dma_data_mem_write  output  1  write enable; top level ORs it with the CPU write.
- data_mem_read_ctrl_by  output  1  0 = CPU, 1 = DMA.
- data_mem_write_ctrl_by  output  1  0 = CPU, 1 = DMA.
- cpu_mem_stall  output  1  freeze the CPU memory stage.
- dma_busy  output  1  engine not in IDLE.
- dma_done  output  1  one-cycle completion pulse.
- dma_error  output  1  valid while dma_done is high: bounds violation.
- dma_aborted  output  1  valid while dma_done is high: abort taken.

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, counter and data buffer are cleared. Reset mid-transfer abandons the transfer immediately; the ctrl_by outputs return to CPU on the next cycle.
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.
- States: IDLE, ACQUIRE, READ, WRITE, DONE.
- IDLE, on dma_start:
  - Latch src, dst and len.
  - len==0 -> DONE with error=0, and the bus is never taken.
  - src+len > NUM_WORDS or dst+len > NUM_WORDS -> DONE with error=1. Compute the sums with DATA_ADDR_WIDTH+1 bits so overflow counts as a violation.
  - Otherwise -> ACQUIRE.
- ACQUIRE:
  - cpu_mem_stall=1, busy=1.
  - Stay until cpu_mem_idle=1, then -> READ.
  - Abort here -> DONE with aborted=1.
- READ:
  - read_ctrl_by=1, raddr=src+idx.
  - Capture data_mem_rdata into the buffer at the clock edge, then -> WRITE.
  - Abort here -> DONE; the current word is not written.
- WRITE:
  - write_ctrl_by=1, waddr=dst+idx, wdata=buffer, dma_data_mem_write=1.
  - idx++. If idx+1==len -> DONE, otherwise -> READ.
  - Abort here: this write still completes, then -> DONE.
- DONE:
  - Lasts one cycle.
  - dma_done=1; error and aborted hold their final values.
  - cpu_mem_stall=0, ctrl_by=0, busy=1.
  - -> IDLE.
- Timing: start accepted in cycle 0 with cpu_mem_idle=1 gives ACQUIRE in cycle 1, first READ in cycle 2, and dma_done in cycle 2N+2. Throughput is 2 cycles/word.
- Copy order is always ascending. Overlap with dst>src deliberately replicates the leading data; software must use dst<src or non-overlapping ranges for a true move.
- dma_start while busy is ignored; no queueing.
- ctrl_by signals are 1 only in READ/WRITE, so the CPU never sees DMA data.

Decomposition:
- Shared package dma_pkg:
  - State encoding (3-bit localparams).
  - CPU_CTRL=0 and DMA_CTRL=1, which the data memory also uses.
- Single module; no sub-module is natural. The index counter and address adders are inline.

Test Plan:
- Preload mem[4..7]=11,22,33,44; start src=4, dst=20, len=4, idle=1 -> mem[20..23]=11,22,33,44; dma_done in cycle 10 with error=0; cpu_mem_stall high in cycles 1-9 only.
- len=0, src=0, dst=0 -> dma_done in cycle 1; ctrl_by never 1; stall never 1.
- src=120, dst=0, len=10 (NUM_WORDS=128) -> dma_done with error=1; no writes; memory unchanged.
- cpu_mem_idle held 0 for 5 cycles after start -> remains in ACQUIRE with stall=1 and ctrl_by=0; copy starts the cycle after idle rises.
- Abort asserted during the 2nd WRITE of a len=4 copy -> exactly 2 words written; dma_done with aborted=1.
- Start pulsed again mid-transfer with different src -> ignored; the original copy completes unchanged. Then assert reset mid-copy -> all outputs 0 the next cycle.
